conv_scale_shift: RTL and testbench
===================================

Name: conv_scale_shift

Overview:
Requantization front-end for the conv output path, sitting directly upstream of the zero-point/ReLU stage. It takes 32-bit signed accumulators for every picture/channel lane, adds a per-channel bias, multiplies by a per-channel scale, and applies a rounding arithmetic right shift. It saturates each lane to signed 16 bit and drives the 16-bit-per-lane bus plus valid consumed by the zero-point stage. Per-channel bias and scale are loaded by a small parameter-load state machine before each layer.

Parameters:
CHANNEL_OUT_NUM, 8, output channels processed in parallel
PIC_NUM, 8, pictures per channel (set equal to `PICTURE_NUM)
ACC_WIDTH, 32, signed accumulator width per lane
SCALE_WIDTH, 16, unsigned per-channel scale width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
load_start  in  1  pulse: begin loading CHANNEL_OUT_NUM parameter beats
param_valid  in  1  parameter beat valid (accepted only in LOAD)
param_bias  in  ACC_WIDTH  signed bias for current channel beat
param_scale  in  SCALE_WIDTH  unsigned scale for current channel beat
param_shift  in  5  per-channel shift (used only with CONV_SHIFT_PER_CHANNEL_EN)
shift_num  in  5  layer-wide right-shift amount 0..31
param_done  out  1  one-cycle pulse when last parameter beat is accepted
ready  out  1  high only in RUN state
data_in_valid  in  1  accumulator bus valid
data_in  in  PIC_NUM*CHANNEL_OUT_NUM*ACC_WIDTH  accumulators; lane k=j*PIC_NUM+i (channel j, picture i)
data_out_valid  out  1  output valid; drives M_Valid_Temp of the zero-point stage
shift_data_out  out  PIC_NUM*CHANNEL_OUT_NUM*16  signed 16-bit results, same lane order

Behaviour:
- Reset: state IDLE; param_done=0, ready=0, data_out_valid=0, shift_data_out=0; bias/scale/shift banks=0; pending flag=0; pipeline valids=0.
- States: IDLE, LOAD, RUN.
  - IDLE -> LOAD on load_start.
  - LOAD: channel counter 0..CHANNEL_OUT_NUM-1; each param_valid beat writes bias/scale (and shift) for channel = counter, then counter increments. The beat at counter = CHANNEL_OUT_NUM-1 pulses param_done the next cycle, clears the counter, and moves to RUN.
  - RUN: data_in_valid accepted every cycle (no backpressure).
  - RUN -> LOAD on load_start only if pipeline empty. Otherwise a pending flag is set, ready drops immediately, and LOAD is entered on the first cycle all stage valids are 0.
- data_in_valid outside RUN is ignored (not entered into pipeline). param_valid outside LOAD is ignored.
- load_start during LOAD restarts the counter at 0.
- Pipeline, fixed latency 4 cycles from accepted data_in_valid to data_out_valid. Fully pipelined, one result set per cycle.
  - S1: sum = sext(acc) + sext(bias[j]), 33-bit signed, no overflow possible.
  - S2: prod = sum * {0,scale[j]}, 50-bit signed.
  - S3: if sh>0, prod += 1<<(sh-1) (round half up toward +inf); then arithmetic shift right by sh.
  - S4: saturate to [-32768, 32767]; register onto shift_data_out.
- shift_data_out holds its last value when data_out_valid=0.
- Reset mid-operation: all in-flight data discarded, valid deasserted the next cycle, parameters lost; reload required.
- sh = shift_num sampled at S3 for the lane's data; shift_num must be stable while RUN.

Optional Feature:
CONV_SHIFT_PER_CHANNEL_EN:
- Defined: param_shift is stored per channel during LOAD, and S3 uses shift[j]; shift_num is ignored.
- Undefined: param_shift is ignored, no shift bank is built, and all lanes use shift_num.

Test Plan:
1. Reset, load 8 beats (bias 0, scale 1), shift_num 0, acc lane0=100 -> 4 cycles later lane0=100, data_out_valid one cycle, param_done pulsed once.
2. Rounding: scale 1, bias 0, shift_num 1; acc 3 -> 2, acc -3 -> -1, acc 2 -> 1.
3. Saturation: acc 0x7FFF0000, scale 2, shift 0 -> 32767; acc 0x80000000, scale 1 -> -32768.
4. Bias/scale per channel: channel 3 bias -50, scale 3, shift 2; acc 10 -> ((-40*3)+2)>>>2 = -30 on lanes 3*PIC_NUM..+7 only.
5. load_start issued with 3 valids in flight -> ready drops at once, 3 outputs still emerge with old params, LOAD entered after drain; data_in_valid during LOAD produces no output.
6. Reset asserted 2 cycles after data_in_valid -> no data_out_valid emerges; outputs 0; ready 0.

Source files
------------

// File: rtl/conv_scale_shift.sv
// conv_scale_shift: per-channel bias + scale + rounding right shift with
// signed 16-bit saturation, feeding the zero-point/ReLU stage.
// Optional macro CONV_SHIFT_PER_CHANNEL_EN: when defined, a per-channel shift
// bank is loaded from param_shift and replaces the layer-wide shift_num.
module conv_scale_shift #(
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int PIC_NUM         = 8,
  parameter int ACC_WIDTH       = 32,
  parameter int SCALE_WIDTH     = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          load_start,
  input  logic                                          param_valid,
  input  logic signed [ACC_WIDTH-1:0]                   param_bias,
  input  logic        [SCALE_WIDTH-1:0]                 param_scale,
  input  logic        [4:0]                             param_shift,
  input  logic        [4:0]                             shift_num,
  output logic                                          param_done,
  output logic                                          ready,
  input  logic                                          data_in_valid,
  input  logic [PIC_NUM*CHANNEL_OUT_NUM*ACC_WIDTH-1:0]  data_in,
  output logic                                          data_out_valid,
  output logic [PIC_NUM*CHANNEL_OUT_NUM*16-1:0]         shift_data_out
);

  localparam int LANES  = PIC_NUM * CHANNEL_OUT_NUM;
  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int PROD_W = SUM_W + SCALE_WIDTH + 1;
  localparam int CNT_W  = (CHANNEL_OUT_NUM > 1) ? $clog2(CHANNEL_OUT_NUM) : 1;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32768);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2} state_t;

  // Add half an LSB of the result (round half toward +inf), then shift arithmetically.
  function automatic logic signed [PROD_W-1:0] round_shift(input logic signed [PROD_W-1:0] p,
                                                           input logic [4:0] sh);
    logic signed [PROD_W-1:0] r;
    if (sh != 5'd0) r = p + (PROD_W'(1) << (sh - 5'd1));
    else            r = p;
    return r >>> sh;
  endfunction

  // Clamp to the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX)      return 16'h7FFF;
    else if (v < SAT_MIN) return 16'h8000;
    else                  return v[15:0];
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic                 param_done_q, param_done_d;
  logic                 ready_q, ready_d;
  logic                 wr_s, accept_s, busy_s;

  logic signed [ACC_WIDTH-1:0]   bias_q  [CHANNEL_OUT_NUM];
  logic signed [ACC_WIDTH-1:0]   bias_d  [CHANNEL_OUT_NUM];
  logic        [SCALE_WIDTH-1:0] scale_q [CHANNEL_OUT_NUM];
  logic        [SCALE_WIDTH-1:0] scale_d [CHANNEL_OUT_NUM];
`ifdef CONV_SHIFT_PER_CHANNEL_EN
  logic [4:0] shift_q [CHANNEL_OUT_NUM];
  logic [4:0] shift_d [CHANNEL_OUT_NUM];
  logic       shift_num_unused_s;
  assign shift_num_unused_s = ^shift_num;
`else
  logic       param_shift_unused_s;
  assign param_shift_unused_s = ^param_shift;
`endif

  logic                     v1_q, v2_q, v3_q, v4_q;
  logic signed [SUM_W-1:0]  s1_q [LANES];
  logic signed [SUM_W-1:0]  s1_d [LANES];
  logic signed [PROD_W-1:0] s2_q [LANES];
  logic signed [PROD_W-1:0] s2_d [LANES];
  logic signed [PROD_W-1:0] s3_q [LANES];
  logic signed [PROD_W-1:0] s3_d [LANES];
  logic [LANES*16-1:0]      out_q, out_d;

  // Data is taken only while ready is registered high; a pending reload stops intake.
  assign accept_s = data_in_valid & ready_q;
  assign busy_s   = v1_q | v2_q | v3_q | v4_q;

  // Parameter-load / run sequencing: next state, channel counter and reload deferral.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    param_done_d = 1'b0;
    wr_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          cnt_d = '0;
        end else if (param_valid) begin
          wr_s = 1'b1;
          if (cnt_q == CNT_W'(CHANNEL_OUT_NUM - 1)) begin
            cnt_d        = '0;
            param_done_d = 1'b1;
            state_d      = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        if (pending_q) begin
          if (!busy_s) begin
            state_d   = ST_LOAD;
            pending_d = 1'b0;
            cnt_d     = '0;
          end else begin
            pending_d = 1'b1;
          end
        end else if (load_start) begin
          if (busy_s || accept_s) begin
            pending_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_RUN) && !pending_d;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      param_done_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      param_done_q <= param_done_d;
      ready_q      <= ready_d;
    end
  end

  // Parameter bank update for the channel addressed by the load counter.
  always_comb begin
    bias_d  = bias_q;
    scale_d = scale_q;
`ifdef CONV_SHIFT_PER_CHANNEL_EN
    shift_d = shift_q;
`endif
    if (wr_s) begin
      bias_d[cnt_q]  = param_bias;
      scale_d[cnt_q] = param_scale;
`ifdef CONV_SHIFT_PER_CHANNEL_EN
      shift_d[cnt_q] = param_shift;
`endif
    end else begin
      bias_d[0] = bias_q[0];
    end
  end

  // Parameter bank registers; cleared by reset so a reload is always required.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL_OUT_NUM; c++) begin
        bias_q[c]  <= '0;
        scale_q[c] <= '0;
`ifdef CONV_SHIFT_PER_CHANNEL_EN
        shift_q[c] <= '0;
`endif
      end
    end else begin
      bias_q  <= bias_d;
      scale_q <= scale_d;
`ifdef CONV_SHIFT_PER_CHANNEL_EN
      shift_q <= shift_d;
`endif
    end
  end

  // Datapath: bias add, scale multiply, rounding shift, saturation; stages hold when idle.
  always_comb begin
    out_d = out_q;
    for (int k = 0; k < LANES; k++) begin
      if (accept_s) s1_d[k] = SUM_W'($signed(data_in[k*ACC_WIDTH +: ACC_WIDTH]))
                              + SUM_W'(bias_q[k / PIC_NUM]);
      else          s1_d[k] = s1_q[k];
      if (v1_q) s2_d[k] = PROD_W'(s1_q[k]) * PROD_W'($signed({1'b0, scale_q[k / PIC_NUM]}));
      else      s2_d[k] = s2_q[k];
`ifdef CONV_SHIFT_PER_CHANNEL_EN
      if (v2_q) s3_d[k] = round_shift(s2_q[k], shift_q[k / PIC_NUM]);
`else
      if (v2_q) s3_d[k] = round_shift(s2_q[k], shift_num);
`endif
      else      s3_d[k] = s3_q[k];
      if (v3_q) out_d[k*16 +: 16] = sat16(s3_q[k]);
      else      out_d[k*16 +: 16] = out_q[k*16 +: 16];
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      out_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
        s3_q[k] <= '0;
      end
    end else begin
      v1_q  <= accept_s;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      v4_q  <= v3_q;
      out_q <= out_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
    end
  end

  assign param_done     = param_done_q;
  assign ready          = ready_q;
  assign data_out_valid = v4_q;
  assign shift_data_out = out_q;

endmodule

// File: tb/tb_conv_scale_shift.sv
// Directed bench for conv_scale_shift: a cycle model built from the arithmetic
// rules checks every cycle, plus hand-computed lane values.
module tb_conv_scale_shift;
  localparam int CH = 8, PIC = 8, LANES = 64, AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, load_start = 1'b0, param_valid = 1'b0, data_in_valid = 1'b0;
  logic signed [AW-1:0] param_bias = '0;
  logic [15:0] param_scale = '0;
  logic [4:0] param_shift = '0, shift_num = '0;
  logic param_done, ready, data_out_valid;
  logic [LANES*AW-1:0] data_in = '0;
  logic [LANES*16-1:0] shift_data_out;

  conv_scale_shift dut (
    .clk(clk), .rst(rst), .load_start(load_start), .param_valid(param_valid),
    .param_bias(param_bias), .param_scale(param_scale), .param_shift(param_shift),
    .shift_num(shift_num), .param_done(param_done), .ready(ready),
    .data_in_valid(data_in_valid), .data_in(data_in),
    .data_out_valid(data_out_valid), .shift_data_out(shift_data_out));

  int errors = 0, checks = 0;
  bit cmp_en = 1'b0;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOAD, M_RUN} mode_t;
  mode_t  m_mode;
  bit     m_pend, m_done;
  int     m_cnt;
  longint m_bias [CH];
  longint m_scale[CH];
  int     m_shf  [CH];
  bit     m_v   [1:4];
  logic [LANES*16-1:0] m_data[1:4];

  function automatic logic [15:0] calc(longint acc, longint bias, longint scale, int sh);
    longint p;
    p = (acc + bias) * scale;
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  function automatic logic [LANES*16-1:0] model_bus(input logic [LANES*AW-1:0] din);
    logic [LANES*16-1:0] r;
    int sh;
    for (int k = 0; k < LANES; k++) begin
`ifdef CONV_SHIFT_PER_CHANNEL_EN
      sh = m_shf[k / PIC];
`else
      sh = int'(shift_num);
`endif
      r[k*16 +: 16] = calc(longint'($signed(din[k*AW +: AW])), m_bias[k / PIC], m_scale[k / PIC], sh);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= M_IDLE; m_pend <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
      for (int c = 0; c < CH; c++) begin m_bias[c] <= 0; m_scale[c] <= 0; m_shf[c] <= 0; end
      for (int i = 1; i <= 4; i++) begin m_v[i] <= 1'b0; m_data[i] <= '0; end
    end else begin
      m_v[1] <= (m_mode == M_RUN) && !m_pend && data_in_valid;
      if ((m_mode == M_RUN) && !m_pend && data_in_valid) m_data[1] <= model_bus(data_in);
      for (int i = 2; i <= 4; i++) begin
        m_v[i] <= m_v[i-1];
        if (m_v[i-1]) m_data[i] <= m_data[i-1];
      end
      m_done <= 1'b0;
      if (m_mode == M_IDLE && load_start) begin
        m_mode <= M_LOAD; m_cnt <= 0;
      end else if (m_mode == M_LOAD && load_start) begin
        m_cnt <= 0;
      end else if (m_mode == M_LOAD && param_valid) begin
        m_bias[m_cnt]  <= longint'($signed(param_bias));
        m_scale[m_cnt] <= longint'(param_scale);
        m_shf[m_cnt]   <= int'(param_shift);
        if (m_cnt == CH - 1) begin m_done <= 1'b1; m_mode <= M_RUN; m_cnt <= 0; end
        else m_cnt <= m_cnt + 1;
      end else if (m_mode == M_RUN && m_pend) begin
        if (!(m_v[1] | m_v[2] | m_v[3] | m_v[4])) begin m_mode <= M_LOAD; m_pend <= 1'b0; m_cnt <= 0; end
      end else if (m_mode == M_RUN && load_start) begin
        if (m_v[1] | m_v[2] | m_v[3] | m_v[4] | data_in_valid) m_pend <= 1'b1;
        else begin m_mode <= M_LOAD; m_cnt <= 0; end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string name, input logic [LANES*16-1:0] act, input logic [LANES*16-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < LANES; k++)
        if (act[k*16 +: 16] !== exp[k*16 +: 16]) begin
          $display("FAIL %s lane %0d: got %h expected %h at %0t", name, k, act[k*16 +: 16], exp[k*16 +: 16], $time);
          break;
        end
    end
  endtask

  function automatic longint lane(input int k);
    return longint'($signed(shift_data_out[k*16 +: 16]));
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk_int("valid", data_out_valid, m_v[4]);
      chk_int("ready", ready, (m_mode == M_RUN) && !m_pend);
      chk_int("param_done", param_done, m_done);
      chk_bus("data", shift_data_out, m_data[4]);
    end
  end

  // ---------------- stimulus ----------------
  longint tb_bias[CH];
  longint tb_scale[CH];
  int     tb_shift[CH];

  task automatic set_params(input longint b, input longint s, input int sh);
    for (int c = 0; c < CH; c++) begin tb_bias[c] = b; tb_scale[c] = s; tb_shift[c] = sh; end
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < LANES; k++) data_in[k*AW +: AW] = 32'(v);
  endtask

  task automatic load_params(input string tag);
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    for (int c = 0; c < CH; c++) begin
      param_valid = 1'b1;
      param_bias  = 32'(tb_bias[c]);
      param_scale = 16'(tb_scale[c]);
      param_shift = 5'(tb_shift[c]);
      @(negedge clk);
    end
    param_valid = 1'b0;
    chk_int({tag, "_done_pulse"}, param_done, 1);
    chk_int({tag, "_ready"}, ready, 1);
    @(negedge clk);
    chk_int({tag, "_done_once"}, param_done, 0);
  endtask

  // Drive one accepted vector at the current negedge and wait for its result.
  task automatic send_and_wait(input string tag, output int lat);
    data_in_valid = 1'b1;
    @(negedge clk); data_in_valid = 1'b0;
    lat = 1;
    while (!data_out_valid && lat < 12) begin @(negedge clk); lat++; end
    if (!data_out_valid) begin
      errors++; checks++;
      $display("FAIL %s_timeout: no data_out_valid after %0d cycles", tag, lat);
    end
  endtask

  int lat, cnt;

  initial begin
    // pin the model to hand-computed values
    chk_int("model_rnd_pos", longint'($signed(calc(3, 0, 1, 1))), 2);
    chk_int("model_rnd_neg", longint'($signed(calc(-3, 0, 1, 1))), -1);
    chk_int("model_ch3", longint'($signed(calc(10, -50, 3, 2))), -30);
    chk_int("model_sat_hi", longint'($signed(calc(32'sh7FFF0000, 0, 2, 0))), 32767);

    // reset
    @(negedge clk); cmp_en = 1'b1;
    @(negedge clk);
    chk_int("rst_valid", data_out_valid, 0);
    chk_int("rst_ready", ready, 0);
    chk_int("rst_data", longint'(shift_data_out == '0), 1);
    rst = 1'b0;

    // 1: identity, latency
    set_params(0, 1, 0); shift_num = 5'd0;
    load_params("t1");
    for (int k = 0; k < LANES; k++) data_in[k*AW +: AW] = 32'(k * 1000 - 30000);
    data_in[0 +: AW] = 32'd100;
    send_and_wait("t1", lat);
    chk_int("t1_latency", lat, 4);
    chk_int("t1_lane0", lane(0), 100);
    chk_int("t1_lane1", lane(1), -29000);
    chk_int("t1_lane63_sat", lane(63), 32767);
    @(negedge clk);
    chk_int("t1_valid_one_cycle", data_out_valid, 0);
    chk_int("t1_hold", lane(0), 100);

    // 2: rounding, three back-to-back vectors
    set_params(0, 1, 1); shift_num = 5'd1;
    load_params("t2");
    set_all(3);  data_in_valid = 1'b1; @(negedge clk);
    set_all(-3); @(negedge clk);
    set_all(2);  @(negedge clk);
    data_in_valid = 1'b0; @(negedge clk);
    chk_int("t2_rnd_3", lane(0), 2);
    @(negedge clk); chk_int("t2_rnd_m3", lane(9), -1);
    @(negedge clk); chk_int("t2_rnd_2", lane(40), 1);

    // 3: saturation
    set_params(0, 2, 0); tb_scale[1] = 1; shift_num = 5'd0;
    load_params("t3");
    set_all(0);
    data_in[0 +: AW] = 32'h7FFF0000;
    data_in[8*AW +: AW] = 32'h80000000;
    send_and_wait("t3", lat);
    chk_int("t3_sat_hi", lane(0), 32767);
    chk_int("t3_sat_lo", lane(8), -32768);
    chk_int("t3_zero", lane(1), 0);

    // 4: per-channel bias/scale
    set_params(0, 1, 2); tb_bias[3] = -50; tb_scale[3] = 3; shift_num = 5'd2;
    load_params("t4");
    set_all(10);
    send_and_wait("t4", lat);
    chk_int("t4_ch3_first", lane(24), -30);
    chk_int("t4_ch3_last", lane(31), -30);
    chk_int("t4_ch2", lane(23), 3);
    chk_int("t4_ch4", lane(32), 3);

    // 5: reload requested with three vectors in flight
    set_all(100); data_in_valid = 1'b1; @(negedge clk);
    set_all(200); @(negedge clk);
    set_all(300); @(negedge clk);
    data_in_valid = 1'b0; load_start = 1'b1; @(negedge clk);
    load_start = 1'b0;
    chk_int("t5_ready_drop", ready, 0);
    chk_int("t5_old_ch3", lane(24), 38);
    chk_int("t5_old_ch0", lane(0), 25);
    set_all(5000); data_in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (data_out_valid) cnt++;
      @(negedge clk);
    end
    chk_int("t5_drain_count", cnt, 3);
    chk_int("t5_last_old", lane(0), 75);
    data_in_valid = 1'b0;
    set_params(0, 1, 0); shift_num = 5'd0;
    load_params("t5");

    // 6: reset mid-flight
    set_all(7); data_in_valid = 1'b1; @(negedge clk);
    data_in_valid = 1'b0; @(negedge clk);
    rst = 1'b1; @(negedge clk);
    chk_int("t6_valid", data_out_valid, 0);
    chk_int("t6_ready", ready, 0);
    chk_int("t6_data", longint'(shift_data_out == '0), 1);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_out_valid) cnt++;
    end
    chk_int("t6_no_output", cnt, 0);
    chk_int("t6_ready_idle", ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
